// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with wait states
// Byte-enabled word storage behind a valid/ready request and response handshake.
module dmem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   old_word;
  logic [31:0]   merged_word;
  logic          mem_we;

  // With zero wait states the commit edge is the acceptance edge itself,
  // so the access fields come straight from the request bus in IDLE.
  always_comb begin
    accept    = req_valid && (state_q == IDLE);
    acc_we    = (state_q == IDLE) ? req_we    : we_q;
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    acc_be    = (state_q == IDLE) ? req_be    : be_q;
    acc_err   = (acc_addr[1:0] != 2'b00) ||
                ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_idx   = acc_addr[AW+1:2];
    old_word  = mem_q[acc_idx];
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = acc_be[i] ? acc_wdata[8*i +: 8] : old_word[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rdata_d = (acc_err || acc_we) ? 32'd0 : old_word;
      err_d   = acc_err;
    end

    mem_we = enter_resp && acc_we && !acc_err;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[acc_idx] <= merged_word;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed-vector bench for dmem_responder
// Instance u_dut uses WAIT_STATES=1, u_dut0 uses WAIT_STATES=0.
module tb_dmem_responder;

  logic        clk;
  logic        a_reset, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int n_vec = 0;
  int n_err = 0;

  dmem_responder #(.DEPTH_WORDS(32), .WAIT_STATES(1)) u_dut (
    .clk(clk), .reset(a_reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(b_reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on u_dut with rsp_ready held high; lat counts
  // cycles from acceptance to the first rsp_valid cycle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int guard;
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    a_rsp_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!a_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!a_rsp_valid && lat < 20);
    rdata = a_rsp_rdata;
    err   = a_rsp_err;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          guard;

  initial begin
    a_reset = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0;
    a_req_wdata = '0; a_req_be = '0; a_rsp_ready = 1'b1;
    b_reset = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
    b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(a_rsp_err),   32'd0);
    check("rst_rsp_rdata", a_rsp_rdata,      32'd0);
    @(posedge clk);
    #1 a_reset = 1'b1;

    do_req(1'b1, 32'h08, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    check("wr08_lat",   32'(lat), 32'd2);
    check("wr08_err",   32'(er),  32'd0);
    check("wr08_rdata", rd,       32'd0);
    do_req(1'b0, 32'h08, 32'h0, 4'b1111, rd, er, lat);
    check("rd08_lat",   32'(lat), 32'd2);
    check("rd08_rdata", rd,       32'hDEADBEEF);

    do_req(1'b1, 32'h08, 32'h11223344, 4'b0101, rd, er, lat);
    do_req(1'b0, 32'h08, 32'h0, 4'b0000, rd, er, lat);
    check("rd08_be0101", rd, 32'hDE22BE44);

    do_req(1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    check("wr_be0_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h08, 32'h0, 4'b1000, rd, er, lat);
    check("rd_after_be0", rd, 32'hDE22BE44);

    do_req(1'b0, 32'h06, 32'h0, 4'b1111, rd, er, lat);
    check("rd06_err",   32'(er), 32'd1);
    check("rd06_rdata", rd,      32'd0);
    do_req(1'b0, 32'h80, 32'h0, 4'b1111, rd, er, lat);
    check("rd80_err",   32'(er), 32'd1);
    check("rd80_rdata", rd,      32'd0);
    do_req(1'b1, 32'h80, 32'h55555555, 4'b1111, rd, er, lat);
    check("wr80_err",   32'(er), 32'd1);
    do_req(1'b1, 32'h0A, 32'h66666666, 4'b1111, rd, er, lat);
    check("wr0A_err",   32'(er), 32'd1);
    do_req(1'b0, 32'h08, 32'h0, 4'b1111, rd, er, lat);
    check("rd08_after_err_wr", rd, 32'hDE22BE44);

    // Response stall with a competing request held on the bus
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h08; a_req_be = 4'b0000;
    @(negedge clk);
    check("stall_accept_ready", 32'(a_req_ready), 32'd1);
    @(posedge clk);
    #1 a_req_we = 1'b1; a_req_addr = 32'h80; a_req_wdata = 32'h77777777;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!a_rsp_valid && guard < 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", 32'(a_rsp_valid), 32'd1);
      check("stall_rdata", a_rsp_rdata,      32'hDE22BE44);
      check("stall_err",   32'(a_rsp_err),   32'd0);
      check("stall_ready", 32'(a_req_ready), 32'd0);
    end
    @(posedge clk);
    #1 a_rsp_ready = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h08;
    @(negedge clk);
    check("hs_cycle_valid", 32'(a_rsp_valid), 32'd1);
    check("hs_cycle_ready", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    check("post_hs_ready", 32'(a_req_ready), 32'd1);
    check("post_hs_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    @(negedge clk);
    check("next_wait_valid", 32'(a_rsp_valid), 32'd0);
    @(negedge clk);
    check("next_rsp_valid", 32'(a_rsp_valid), 32'd1);
    check("next_rsp_rdata", a_rsp_rdata,      32'hDE22BE44);
    @(posedge clk);
    #1;

    // Reset while a write sits in WAIT
    do_req(1'b1, 32'h04, 32'hAAAA0000, 4'b1111, rd, er, lat);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h04;
    a_req_wdata = 32'h12345678; a_req_be = 4'b1111;
    @(negedge clk);
    @(posedge clk);
    #1 a_req_valid = 1'b0; a_reset = 1'b0;
    @(negedge clk);
    check("rstwait_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge clk);
    #1 a_reset = 1'b1;
    @(negedge clk);
    check("rstrel_valid", 32'(a_rsp_valid), 32'd0);
    check("rstrel_ready", 32'(a_req_ready), 32'd1);
    do_req(1'b0, 32'h04, 32'h0, 4'b1111, rd, er, lat);
    check("rd04_unchanged", rd, 32'hAAAA0000);

    // Zero wait states: write then back-to-back reads with the request held
    @(posedge clk);
    #1 b_reset = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h0;
    b_req_wdata = 32'hCAFEF00D; b_req_be = 4'b1111; b_rsp_ready = 1'b1;
    @(negedge clk);
    check("ws0_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    #1 b_req_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("ws0_rsp_valid", 32'(b_rsp_valid), 32'((k % 2) == 1));
      check("ws0_req_ready", 32'(b_req_ready), 32'((k % 2) == 0));
      if (k == 1) check("ws0_wr_rdata", b_rsp_rdata, 32'd0);
      if (k == 3 || k == 7) check("ws0_rd_rdata", b_rsp_rdata, 32'hCAFEF00D);
    end
    b_req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 32, giving the number of 32-bit storage words.
REQ-002 The module SHALL have parameter WAIT_STATES, default 1, giving the number of extra cycles between request acceptance and response (legal range 0-15).
REQ-003 The module SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_be  input  4  byte enables for writes; bit i covers bits 8i+7:8i.
REQ-012 rsp_valid  output  1  response is present.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  read data; 0 for writes and for errors.
REQ-015 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE, with rsp_valid 0.
REQ-018 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; accepting it latches we, addr, wdata and be.
REQ-019 After acceptance the FSM SHALL go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else directly to RESP.
REQ-020 In WAIT the counter SHALL decrement each cycle; at counter 0 the FSM goes to RESP on the next edge.
REQ-021 The memory access SHALL be committed on the edge that enters RESP: a write updates the enabled bytes, and a read captures the addressed word into rsp_rdata.
REQ-022 rsp_valid SHALL be 1 exactly while in RESP; the first rsp_valid cycle is acceptance cycle + 1 + WAIT_STATES.
REQ-023 In RESP, rsp_rdata and rsp_err SHALL hold stable until rsp_valid and rsp_ready are both 1, then the FSM returns to IDLE.
REQ-024 A new request SHALL be accepted no earlier than the cycle after the response handshake (no overlap; maximum 1 outstanding).
REQ-025 Word index SHALL be req_addr[31:2].
REQ-026 An error SHALL be raised when req_addr[1:0] != 0 or word index >= DEPTH_WORDS.
REQ-027 An error response SHALL assert rsp_err=1 with rsp_rdata=0, and memory SHALL NOT be modified.
REQ-028 A write with req_be=0000 SHALL complete normally with no bytes changed.
REQ-029 A read SHALL ignore req_be and return the full word.
REQ-030 A read following a write to the same word SHALL return the post-write value.
REQ-031 Input changes while not in IDLE SHALL be ignored.

Reset
REQ-032 While reset=0 at a rising edge, the FSM SHALL go to IDLE, with counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=1 on the following cycle.
REQ-033 Reset in WAIT SHALL abort the request; the write is not committed and no response is issued.
REQ-034 Reset in RESP SHALL drop rsp_valid; an already committed write remains.
REQ-035 Storage contents SHALL NOT be cleared by reset; they are undefined until written.

Verification
REQ-036 WAIT_STATES=1, write addr 0x08, wdata 0xDEADBEEF, be 1111, rsp_ready=1 -> rsp_valid two cycles after acceptance, rsp_err=0, rsp_rdata=0; a subsequent read of 0x08 returns 0xDEADBEEF.
REQ-037 Word 0x08 holds 0xDEADBEEF; write 0x08 wdata 0x11223344 be 0101 -> read returns 0xDE22BE44.
REQ-038 Read addr 0x06 (misaligned) and read addr 0x80 (index 32 with DEPTH_WORDS=32) -> rsp_err=1, rsp_rdata=0; a write to 0x80 leaves all words unchanged.
REQ-039 rsp_ready=0 for 5 cycles during a read response -> rsp_valid, rsp_rdata and rsp_err stay constant, req_ready stays 0, and a new req_valid is not accepted until the cycle after handshake.
REQ-040 Assert reset=0 during WAIT of a write 0x04 = 0x12345678 -> word 0x04 unchanged, no rsp_valid, req_ready=1 the cycle after reset releases.
REQ-041 WAIT_STATES=0, back-to-back reads with rsp_ready=1 -> rsp_valid at acceptance+1, and one request accepted every 2 cycles.
